// File: rtl/line_mem_responder.sv
// Off-chip line memory model answering dcache line reads/writes after a fixed latency.
// One request is outstanding at a time, and a single-cycle ack marks its completion.
module line_mem_responder #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int DEPTH    = 512,
  parameter int LATENCY  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  addr_idx;
  logic              enter_ack_d;
  logic              op_write_d;
  logic [IDX_W-1:0]  op_idx_d;
  logic [DATA_W-1:0] op_data_d;
  logic              unused_addr_bits;

  assign addr_idx         = addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // The memory operation happens on the edge entering ACK; with LATENCY==1 that is the
  // acceptance edge itself, so the operands come straight from the inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    enter_ack_d = 1'b0;
    op_write_d  = write_q;
    op_idx_d    = idx_q;
    op_data_d   = wdata_q;
    if (state_q == IDLE) begin
      enter_ack_d = enable_i && (LATENCY == 1);
      op_write_d  = write_i;
      op_idx_d    = addr_idx;
      op_data_d   = data_i;
    end else if (state_q == WAIT) begin
      enter_ack_d = (cnt_q == CNT_W'(1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            write_q <= write_i;
            idx_q   <= addr_idx;
            wdata_q <= data_i;
            cnt_q   <= CNT_INIT;
            state_q <= enter_ack_d ? ACK : WAIT;
            ack_q   <= enter_ack_d;
          end
        end
        WAIT: begin
          if (enter_ack_d) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (enter_ack_d && !op_write_d) begin
        rdata_q <= mem_q[op_idx_d];
      end
    end
  end

  // NOTE: the line storage deliberately has no reset; only control and output registers do.
  // Gating on rst_i keeps a write that coincides with reset from being committed.
  always_ff @(posedge clk_i) begin
    if (enter_ack_d && op_write_d && !rst_i) begin
      mem_q[op_idx_d] <= op_data_d;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rdata_q;
  assign busy_o = (state_q != IDLE);

endmodule
